// File: rtl/frame_update_scheduler.sv
// Once-per-frame game-logic sequencer. Watches the beam counters and, at the start of
// vertical blanking, launches NUM_TASKS update engines one after another using a
// start pulse / done handshake. A chain still running when the frame wraps is aborted
// and recorded in a sticky overrun flag.
module frame_update_scheduler #(
  parameter int unsigned H_MAX     = 239,
  parameter int unsigned V_DISPLAY = 60,
  parameter int unsigned V_MAX     = 104,
  parameter int unsigned NUM_TASKS = 4,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [9:0]           hpos_i,
  input  logic [9:0]           vpos_i,
  input  logic                 enable_i,
  input  logic [NUM_TASKS-1:0] task_done_i,
  input  logic                 clear_overrun_i,
  output logic [NUM_TASKS-1:0] task_start_o,
  output logic [2:0]           current_task_o,
  output logic                 busy_o,
  output logic                 frame_tick_o,
  output logic [15:0]          frame_count_o,
  output logic                 overrun_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [3:0]           div_cnt_q, div_cnt_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic                 overrun_q, overrun_d;

  logic                 vs_event;
  logic                 fe_event;
  logic [NUM_TASKS-1:0] idx_onehot;
  logic                 done_sel;
  logic                 last_task;

  // Beam events: vblank start and the very last pixel of the frame.
  assign vs_event = (hpos_i == 10'(0)) && (vpos_i == 10'(V_DISPLAY));
  assign fe_event = (hpos_i == 10'(H_MAX)) && (vpos_i == 10'(V_MAX));

  // Only the done bit of the task currently being waited on is ever looked at.
  assign idx_onehot = {{(NUM_TASKS-1){1'b0}}, 1'b1} << idx_q;
  assign done_sel   = |(task_done_i & idx_onehot);
  assign last_task  = (idx_q == 3'(NUM_TASKS - 1));

  // Next-state logic: frame bookkeeping, chain sequencing and overrun abort.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    div_cnt_d     = div_cnt_q;
    frame_tick_d  = 1'b0;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;

    if (clear_overrun_i) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (vs_event) begin
          frame_tick_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          // The divider runs on every frame so the launch cadence is independent of enable.
          div_cnt_d     = (div_cnt_q == 4'(FRAME_DIV - 1)) ? 4'd0 : div_cnt_q + 4'd1;
          if (enable_i && (div_cnt_q == 4'd0)) begin
            state_d = StIssue;
            idx_d   = 3'd0;
          end
        end
      end
      // Done is deliberately not sampled here; engines answer at least a cycle later.
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (done_sel) begin
          if (last_task) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StIssue;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Frame wrapped with a chain still active: abort, beating any same-cycle done or clear.
    if (fe_event && (state_q != StIdle)) begin
      overrun_d = 1'b1;
      state_d   = StIdle;
      idx_d     = 3'd0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      idx_q         <= 3'd0;
      div_cnt_q     <= 4'd0;
      frame_tick_q  <= 1'b0;
      frame_count_q <= 16'd0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      div_cnt_q     <= div_cnt_d;
      frame_tick_q  <= frame_tick_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    task_start_o   = (state_q == StIssue) ? idx_onehot : '0;
    busy_o         = (state_q != StIdle);
    current_task_o = idx_q;
    frame_tick_o   = frame_tick_q;
    frame_count_o  = frame_count_q;
    overrun_o      = overrun_q;
  end

endmodule
